i2c_bus_arbiter: RTL and testbench

- Shares the single I2C byte-level master between NUM_REQ sensor controllers, for example the BH1750 light controller and a second sensor sequencer.
- Arbitration is round-robin at transaction-group level. A requester holds the bus across multi-byte sequences such as a high/low data read.
- A watchdog forcibly reclaims the bus from a stalled requester or a hung master.
- Sits between the sensor controllers and the I2C master, in the same clk domain.

---
 rtl/i2c_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C byte-level master between NUM_REQ requesters.
// A grant is held for a whole transaction group; a watchdog reclaims a stalled grant.
module i2c_bus_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 4_800_000,
   parameter int CNT_W          = 23
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     req_start,
   input  logic [7*NUM_REQ-1:0]   req_addr,
   input  logic [NUM_REQ-1:0]     req_rw,
   input  logic [8*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     req_done,
   output logic [7:0]             req_rdata,
   output logic                   req_nack,
   output logic [NUM_REQ-1:0]     timeout,
   output logic                   m_start,
   output logic [6:0]             m_addr,
   output logic                   m_rw,
   output logic [7:0]             m_wdata,
   input  logic                   m_busy,
   input  logic                   m_done,
   input  logic [7:0]             m_rdata,
   input  logic                   m_nack
);

   localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT   = 2'd1;
   localparam logic [1:0] XFER    = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   // First set request at or above ptr, wrapping around.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] ptr,
                                                 input logic [NUM_REQ-1:0] r);
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] sel;
      logic             found;
      sel   = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
         sel   = (!found && r[idx]) ? idx : sel;
         found = found | r[idx];
      end
      return sel;
   endfunction

   logic [1:0]         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   g_q, g_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [CNT_W-1:0]   wd_q, wd_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [NUM_REQ-1:0] to_q, to_d;
   logic [7:0]         rdata_q, rdata_d;
   logic               nack_q, nack_d;
   logic               mst_q, mst_d;
   logic [6:0]         maddr_q, maddr_d;
   logic               mrw_q, mrw_d;
   logic [7:0]         mwd_q, mwd_d;

   logic [IDX_W-1:0]   nxt_ptr_s;
   logic [IDX_W-1:0]   pick_s;
   logic               wd_exp_s;

   // Arbitration, transaction hand-off and watchdog next-state logic.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      g_d      = g_q;
      rr_d     = rr_q;
      wd_d     = wd_q;
      done_d   = '0;
      to_d     = '0;
      rdata_d  = rdata_q;
      nack_d   = nack_q;
      mst_d    = 1'b0;
      maddr_d  = maddr_q;
      mrw_d    = mrw_q;
      mwd_d    = mwd_q;
      nxt_ptr_s = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);
      pick_s    = rr_pick((state_q == RELEASE) ? nxt_ptr_s : rr_q, req);
      wd_exp_s  = (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));
      case (state_q)
         IDLE: begin
            if (|req) begin
               g_d     = pick_s;
               gnt_d   = NUM_REQ'(1) << pick_s;
               wd_d    = '0;
               state_d = GRANT;
            end else begin
               gnt_d   = '0;
            end
         end
         GRANT: begin
            // A start coinciding with req falling still wins; release follows the transfer.
            if (req_start[g_q] && !m_busy) begin
               mst_d   = 1'b1;
               maddr_d = req_addr[7*int'(g_q) +: 7];
               mrw_d   = req_rw[g_q];
               mwd_d   = req_wdata[8*int'(g_q) +: 8];
               wd_d    = '0;
               state_d = XFER;
            end else if (!req[g_q]) begin
               gnt_d   = '0;
               state_d = RELEASE;
            end else if (wd_exp_s) begin
               to_d    = gnt_q;
               gnt_d   = '0;
               state_d = RELEASE;
            end else begin
               wd_d    = wd_q + CNT_W'(1);
            end
         end
         XFER: begin
            if (m_done) begin
               done_d  = gnt_q;
               rdata_d = m_rdata;
               nack_d  = m_nack;
               wd_d    = '0;
               if (req[g_q]) begin
                  state_d = GRANT;
               end else begin
                  gnt_d   = '0;
                  state_d = RELEASE;
               end
            end else if (wd_exp_s) begin
               to_d    = gnt_q;
               gnt_d   = '0;
               state_d = RELEASE;
            end else begin
               wd_d    = wd_q + CNT_W'(1);
            end
         end
         RELEASE: begin
            // Re-arbitrate here so the grant gap is exactly this one cycle.
            rr_d = nxt_ptr_s;
            if (|req) begin
               g_d     = pick_s;
               gnt_d   = NUM_REQ'(1) << pick_s;
               wd_d    = '0;
               state_d = GRANT;
            end else begin
               gnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         g_q     <= '0;
         rr_q    <= '0;
         wd_q    <= '0;
         done_q  <= '0;
         to_q    <= '0;
         rdata_q <= 8'h00;
         nack_q  <= 1'b0;
         mst_q   <= 1'b0;
         maddr_q <= 7'h00;
         mrw_q   <= 1'b0;
         mwd_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         g_q     <= g_d;
         rr_q    <= rr_d;
         wd_q    <= wd_d;
         done_q  <= done_d;
         to_q    <= to_d;
         rdata_q <= rdata_d;
         nack_q  <= nack_d;
         mst_q   <= mst_d;
         maddr_q <= maddr_d;
         mrw_q   <= mrw_d;
         mwd_q   <= mwd_d;
      end
   end

   assign gnt       = gnt_q;
   assign req_done  = done_q;
   assign req_rdata = rdata_q;
   assign req_nack  = nack_q;
   assign timeout   = to_q;
   assign m_start   = mst_q;
   assign m_addr    = maddr_q;
   assign m_rw      = mrw_q;
   assign m_wdata   = mwd_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with two requesters and a 100-cycle watchdog.
module tb_i2c_bus_arbiter;

   logic        clk;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  req_start;
   logic [13:0] req_addr;
   logic [1:0]  req_rw;
   logic [15:0] req_wdata;
   logic [1:0]  gnt;
   logic [1:0]  req_done;
   logic [7:0]  req_rdata;
   logic        req_nack;
   logic [1:0]  timeout;
   logic        m_start;
   logic [6:0]  m_addr;
   logic        m_rw;
   logic [7:0]  m_wdata;
   logic        m_busy;
   logic        m_done;
   logic [7:0]  m_rdata;
   logic        m_nack;

   int n_vec;
   int n_bad;
   int cnt;

   i2c_bus_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(100), .CNT_W(23)) dut (
      .clk(clk), .reset(reset), .req(req), .req_start(req_start),
      .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
      .gnt(gnt), .req_done(req_done), .req_rdata(req_rdata), .req_nack(req_nack),
      .timeout(timeout), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw),
      .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata),
      .m_nack(m_nack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      req       = 2'b00;
      req_start = 2'b00;
      m_done    = 1'b0;
      m_busy    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset = 1'b0;
      req = 2'b00; req_start = 2'b00; req_addr = 14'h0; req_rw = 2'b00; req_wdata = 16'h0;
      m_busy = 1'b0; m_done = 1'b0; m_rdata = 8'h00; m_nack = 1'b0;
      do_reset();

      // reset state
      check_val("rst_gnt", 32'(gnt), 32'h0);
      check_val("rst_mstart", 32'(m_start), 32'h0);
      check_val("rst_done", 32'(req_done), 32'h0);
      check_val("rst_to", 32'(timeout), 32'h0);

      // single write transaction
      req = 2'b01;
      tick();
      check_val("t1_gnt", 32'(gnt), 32'h1);
      req_start = 2'b01; req_addr[6:0] = 7'h23; req_rw[0] = 1'b0; req_wdata[7:0] = 8'h01;
      tick();
      req_start = 2'b00;
      check_val("t1_mstart", 32'(m_start), 32'h1);
      check_val("t1_maddr", 32'(m_addr), 32'h23);
      check_val("t1_mwdata", 32'(m_wdata), 32'h01);
      check_val("t1_mrw", 32'(m_rw), 32'h0);
      tick();
      check_val("t1_mstart_pulse", 32'(m_start), 32'h0);
      m_done = 1'b1; m_rdata = 8'h55;
      tick();
      m_done = 1'b0;
      check_val("t1_done", 32'(req_done), 32'h1);
      tick();
      check_val("t1_done_pulse", 32'(req_done), 32'h0);

      // round-robin with one-cycle release gap
      do_reset();
      req = 2'b11;
      tick();
      check_val("t2_gnt0", 32'(gnt), 32'h1);
      req = 2'b10;
      tick();
      check_val("t2_gap", 32'(gnt), 32'h0);
      tick();
      check_val("t2_gnt1", 32'(gnt), 32'h2);
      req = 2'b00;
      tick();
      check_val("t2_rel1", 32'(gnt), 32'h0);
      tick();
      req = 2'b11;
      tick();
      check_val("t2_wrap", 32'(gnt), 32'h1);

      // two reads held in one group
      req_start = 2'b01; req_rw[0] = 1'b1;
      tick();
      req_start = 2'b00;
      check_val("t3_mrw", 32'(m_rw), 32'h1);
      tick();
      m_done = 1'b1; m_rdata = 8'hDE; m_nack = 1'b0;
      tick();
      m_done = 1'b0;
      check_val("t3_done_a", 32'(req_done), 32'h1);
      check_val("t3_rdata_a", 32'(req_rdata), 32'hDE);
      check_val("t3_gnt_a", 32'(gnt), 32'h1);
      req_start = 2'b01;
      tick();
      req_start = 2'b00;
      check_val("t3_gnt_mid", 32'(gnt), 32'h1);
      check_val("t3_mstart_b", 32'(m_start), 32'h1);
      tick();
      m_done = 1'b1; m_rdata = 8'hAD; m_nack = 1'b1;
      tick();
      m_done = 1'b0; m_nack = 1'b0;
      check_val("t3_done_b", 32'(req_done), 32'h1);
      check_val("t3_rdata_b", 32'(req_rdata), 32'hAD);
      check_val("t3_nack_b", 32'(req_nack), 32'h1);

      // foreign start and busy master are ignored
      req_start = 2'b10;
      tick();
      req_start = 2'b00;
      check_val("t4_foreign_ms", 32'(m_start), 32'h0);
      check_val("t4_gnt", 32'(gnt), 32'h1);
      tick();
      check_val("t4_foreign_done", 32'(req_done), 32'h0);
      m_busy = 1'b1; req_start = 2'b01;
      tick();
      req_start = 2'b00; m_busy = 1'b0;
      check_val("t4_busy_ms", 32'(m_start), 32'h0);

      // watchdog in GRANT
      do_reset();
      req = 2'b01;
      tick();
      check_val("t5_gnt", 32'(gnt), 32'h1);
      req = 2'b11;
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (timeout == 2'b00 && cnt < 150);
      check_val("t5_to_cycles", 32'(cnt), 32'd100);
      check_val("t5_to", 32'(timeout), 32'h1);
      check_val("t5_gnt_off", 32'(gnt), 32'h0);
      tick();
      check_val("t5_next_gnt", 32'(gnt), 32'h2);
      check_val("t5_to_pulse", 32'(timeout), 32'h0);

      // watchdog in XFER with late m_done
      req_start = 2'b10; req_addr[13:7] = 7'h5A; req_wdata[15:8] = 8'h3C; req_rw[1] = 1'b0;
      tick();
      req_start = 2'b00;
      check_val("t6_maddr", 32'(m_addr), 32'h5A);
      check_val("t6_mwdata", 32'(m_wdata), 32'h3C);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (timeout == 2'b00 && cnt < 150);
      check_val("t6_to_cycles", 32'(cnt), 32'd100);
      check_val("t6_to", 32'(timeout), 32'h2);
      check_val("t6_gnt_off", 32'(gnt), 32'h0);
      tick();
      check_val("t6_next_gnt", 32'(gnt), 32'h1);
      m_done = 1'b1; m_rdata = 8'h77;
      tick();
      m_done = 1'b0;
      check_val("t6_late_done", 32'(req_done), 32'h0);

      // async reset while requester 1 is mid-transfer
      req = 2'b10;
      tick();
      tick();
      check_val("t7_gnt1", 32'(gnt), 32'h2);
      req_start = 2'b10;
      tick();
      req_start = 2'b00;
      check_val("t7_mstart", 32'(m_start), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check_val("t7_rst_gnt", 32'(gnt), 32'h0);
      check_val("t7_rst_ms", 32'(m_start), 32'h0);
      check_val("t7_rst_done", 32'(req_done), 32'h0);
      req = 2'b00;
      tick();
      reset = 1'b1;
      req = 2'b11;
      tick();
      check_val("t7_after_rst", 32'(gnt), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
